// File: rtl/gbuff_pkg.sv
// Shared defaults and state encoding for the global-buffer reader.
package gbuff_pkg;

   localparam int WORD_SIZE_DEF = 32;
   localparam int INDX_SIZE_DEF = 8;
   localparam int LEN_SIZE_DEF  = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } gb_state_t;

endpackage

// File: rtl/gbuff_skid_fifo.sv
// Two-entry FIFO that absorbs buffer read data while the stream is stalled.
module gbuff_skid_fifo
   import gbuff_pkg::*;
#(
   parameter int WIDTH = WORD_SIZE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   // A push into a full FIFO is only accepted if the head leaves in the same cycle.
   assign w_push  = i_push && (!o_full || i_pop);
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign o_data  = r_mem[r_rd_ptr];

   // Storage needs no reset; occupancy tracking decides what is visible.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/gbuff_reader.sv
// Streams a contiguous run of global-buffer words out on a valid/ready port.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; first read launched with the start
// ST_RUN   | issuing reads, throttled by the 2-word credit
// ST_DRAIN | all reads issued, waiting for the stream to accept them
// ST_DONE  | one-cycle done pulse
module gbuff_reader
   import gbuff_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int INDX_SIZE = INDX_SIZE_DEF,
   parameter int LEN_SIZE  = LEN_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [INDX_SIZE-1:0] base,
   input  logic [LEN_SIZE-1:0]  len,
   output logic                 busy,
   output logic                 done,
   output logic                 gb_wr_en,
   output logic [INDX_SIZE-1:0] gb_index,
   input  logic [WORD_SIZE-1:0] gb_data_out,
   output logic                 m_valid,
   output logic [WORD_SIZE-1:0] m_data,
   input  logic                 m_ready
);

   gb_state_t            r_state;
   gb_state_t            w_state_next;
   logic [INDX_SIZE-1:0] r_addr;
   logic [INDX_SIZE-1:0] r_last_idx;
   logic [LEN_SIZE-1:0]  r_issue_cnt;
   logic [LEN_SIZE-1:0]  r_acc_cnt;
   logic [LEN_SIZE-1:0]  w_acc_next;
   logic                 r_rd_pend;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [1:0]           w_occ;
   logic [2:0]           w_occ_after;
   logic                 w_pop;
   logic                 w_issue_first;
   logic                 w_issue_run;
   logic                 w_issue;
   logic [INDX_SIZE-1:0] w_issue_idx;
   logic                 w_acc_dec;

   // The first read goes out in the cycle start is accepted so the first
   // word reaches the stream two cycles later; later reads come from RUN.
   // The credit counts occupancy after this cycle's pop plus the read in
   // flight, which keeps at most two words outstanding yet sustains one
   // word per cycle while the stream is ready.
   assign w_pop         = m_valid && m_ready;
   assign w_occ         = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
   assign w_occ_after   = {1'b0, w_occ} - {2'b00, w_pop} + {2'b00, r_rd_pend};
   assign w_issue_first = (r_state == ST_IDLE) && start && (len != '0);
   assign w_issue_run   = (r_state == ST_RUN) && (r_issue_cnt != '0) && (w_occ_after < 3'd2);
   assign w_issue       = w_issue_first || w_issue_run;
   assign w_issue_idx   = w_issue_first ? base : r_addr;
   assign gb_index      = w_issue ? w_issue_idx : r_last_idx;
   assign w_acc_dec     = w_pop && (r_acc_cnt != '0);
   assign w_acc_next    = w_acc_dec ? (r_acc_cnt - 1'b1) : r_acc_cnt;
   assign m_valid       = !w_fifo_empty;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (start) w_state_next = (len == '0) ? ST_DONE : ST_RUN;
         ST_RUN: begin
            if (w_acc_next == '0)        w_state_next = ST_DONE;
            else if (r_issue_cnt == '0)  w_state_next = ST_DRAIN;
         end
         ST_DRAIN: if (w_acc_next == '0) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
      done     = (r_state == ST_DONE);
      gb_wr_en = 1'b0;
   end

   // Address, issue and accept counters plus the read-in-flight flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr      <= '0;
         r_last_idx  <= '0;
         r_issue_cnt <= '0;
         r_acc_cnt   <= '0;
         r_rd_pend   <= 1'b0;
      end else begin
         r_rd_pend <= w_issue;
         if (w_issue) r_last_idx <= w_issue_idx;
         if (w_issue_first) begin
            r_addr      <= base + 1'b1;
            r_issue_cnt <= len - 1'b1;
            r_acc_cnt   <= len;
         end else begin
            if (w_issue_run) begin
               r_addr      <= r_addr + 1'b1;
               r_issue_cnt <= r_issue_cnt - 1'b1;
            end
            r_acc_cnt <= w_acc_next;
         end
      end
   end

   gbuff_skid_fifo #(
      .WIDTH (WORD_SIZE)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (r_rd_pend),
      .i_data  (gb_data_out),
      .i_pop   (w_pop),
      .o_data  (m_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

endmodule

// File: doc/gbuff_reader.md
GBUFF_READER -- requirements
Module: gbuff_reader

Interface
REQ-001 Parameter WORD_SIZE, default 32: width of one buffer word and of the output stream.
REQ-002 Parameter INDX_SIZE, default 8: buffer index width (256 entries).
REQ-003 Parameter LEN_SIZE, default 9: transfer-length width; maximum length is 256 words.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse requesting a transfer; sampled only in IDLE.
REQ-007 base  input  INDX_SIZE  first buffer index, sampled with start.
REQ-008 len  input  LEN_SIZE  word count, sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-011 gb_wr_en  output  1  buffer write enable; held 0 (read-only initiator).
REQ-012 gb_index  output  INDX_SIZE  buffer index presented for a read.
REQ-013 gb_data_out  input  WORD_SIZE  buffer read data, registered by the buffer one cycle after the index.
REQ-014 m_valid  output  1  stream word valid.
REQ-015 m_data  output  WORD_SIZE  stream word.
REQ-016 m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both high.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE + start with len!=0 -> RUN; latch base into the address counter and len into the issue and accept counters.
REQ-019 IDLE + start with len==0 -> DONE; no reads are issued.
REQ-020 RUN: issue one read per cycle (gb_index = address counter, rd_pend set next cycle) only while issue count is nonzero and (FIFO occupancy + reads in flight) < 2.
REQ-021 Each issue increments the address modulo 2^INDX_SIZE (index 255 wraps to 0) and decrements the issue count.
REQ-022 When rd_pend is high, the block captures gb_data_out into the 2-entry FIFO in that cycle; no read data is dropped or duplicated.
REQ-023 RUN -> DRAIN when the issue count reaches 0.
REQ-024 DRAIN -> DONE when the accept count reaches 0; the accept count decrements on each m_valid&&m_ready.
REQ-025 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-026 m_valid = FIFO not empty; m_data = FIFO head; words leave in ascending index order.
REQ-027 Simultaneous FIFO push and pop at occupancy 2 is not reachable because of the credit rule; at occupancy 1 both take effect.
REQ-028 Latency: the first word is valid 2 cycles after start, and throughput is 1 word per cycle while m_ready is held high.
REQ-029 m_ready low stalls issue once credits are exhausted; m_data remains stable while m_valid && !m_ready.
REQ-030 start while busy is ignored.
REQ-031 When gb_index is not issuing, it holds its last value.

Reset
REQ-032 On rst low, asynchronously: state=IDLE, busy=0, done=0, m_valid=0, FIFO empty, rd_pend=0, gb_wr_en=0, gb_index=0, counters=0.
REQ-033 Reset mid-transfer aborts the transfer; after release, the block waits for a new start and emits no stale words.

Structure
REQ-034 Package gbuff_pkg holds the WORD_SIZE/INDX_SIZE/LEN_SIZE defaults and the state encoding.
REQ-035 Sub-module gbuff_skid_fifo is a 2-entry, WORD_SIZE-wide FIFO with push/pop/full/empty, async active-low reset, instantiated once.

Verification
REQ-036 Buffer model with word[i]=i+100; start base=4 len=3, m_ready=1 -> m_data 104,105,106 on consecutive cycles, first at start+2, done one cycle after the last word.
REQ-037 base=254 len=4 -> gb_index sequence 254,255,0,1; data 354,355,100,101.
REQ-038 len=0 -> done exactly 1 cycle after start, no gb_index change, m_valid stays 0.
REQ-039 base=0 len=8, m_ready toggled 1,0,0,1,… -> exactly 8 words in order 100..107; m_data is stable during stalls and FIFO occupancy never exceeds 2.
REQ-040 rst asserted 2 cycles into a len=10 transfer -> all outputs are at reset values immediately; a later start base=0 len=2 yields only 100,101.
REQ-041 A second start pulse mid-transfer -> ignored; word count and done timing are unchanged.
